// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the line-granular pmem responder: line/address types,
// FSM state encoding and latency-counter width.
package pmem_types;

  typedef logic [127:0] pmem_line_t;
  typedef logic [11:0]  pmem_ladr_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;

  localparam int PMEM_LAT_W = 4;

  // Counter preload: the accept cycle itself counts as one cycle of latency.
  function automatic logic [PMEM_LAT_W-1:0] lat_load(input int lat);
    return PMEM_LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/pmem_line_store.sv
// Line storage for the pmem responder: synchronous write, combinational read.
module pmem_line_store
  import pmem_types::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_WIDTH-1:0] rdata
);

  logic [LINE_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency line memory responder with sticky protocol-error detection.
// Optional PMEM_STATS_EN adds saturating read_count/write_count outputs.
module pmem_line_responder
  import pmem_types::*;
#(
  parameter int LINE_ADDR_WIDTH = 12,
  parameter int LINE_WIDTH      = 128,
  parameter int DEPTH_LOG2      = 12,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pmem_read,
  input  logic                       pmem_write,
  input  logic [LINE_ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0]      pmem_wdata,
  output logic                       pmem_resp,
  output logic [LINE_WIDTH-1:0]      pmem_rdata,
  output logic                       protocol_err
`ifdef PMEM_STATS_EN
  ,
  output logic [31:0]                read_count,
  output logic [31:0]                write_count
`endif
);

  pmem_state_t           state, state_nx;
  logic [PMEM_LAT_W-1:0] cnt, cnt_nx;
  logic [DEPTH_LOG2-1:0] idx_q, rd_idx;
  logic [LINE_WIDTH-1:0] wdata_q, store_rdata;
  logic                  op_wr, hold, err_set, load_rdata, commit, cur_wr;
  int                    lat_now;

  generate
    if (LINE_ADDR_WIDTH > DEPTH_LOG2) begin : g_alias
      logic unused_alias_bits;
      assign unused_alias_bits = ^pmem_address[LINE_ADDR_WIDTH-1:DEPTH_LOG2];
    end
  endgenerate

  // A read is only still valid while write stays low; any change aborts.
  assign hold = op_wr ? pmem_write : (pmem_read & ~pmem_write);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_set  = 1'b0;
    lat_now  = pmem_write ? WRITE_LATENCY : READ_LATENCY;
    case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          cnt_nx   = lat_load(lat_now);
          state_nx = (lat_now == 1) ? RESP : BUSY;
          err_set  = pmem_read & pmem_write;
        end
      end
      BUSY: begin
        if (!hold) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          err_set  = 1'b1;
        end else begin
          cnt_nx = cnt - PMEM_LAT_W'(1);
          if (cnt == PMEM_LAT_W'(1)) state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cur_wr     = (state == IDLE) ? pmem_write : op_wr;
  assign rd_idx     = (state == IDLE) ? pmem_address[DEPTH_LOG2-1:0] : idx_q;
  assign load_rdata = (state_nx == RESP) && !cur_wr;
  assign commit     = (state == RESP) && op_wr;
  assign pmem_resp  = (state == RESP);

  pmem_line_store #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_store (
    .clk  (clk),
    .we   (commit),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(rd_idx),
    .rdata(store_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      op_wr        <= 1'b0;
      pmem_rdata   <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && (pmem_read || pmem_write)) begin
        idx_q   <= pmem_address[DEPTH_LOG2-1:0];
        wdata_q <= pmem_wdata;
        op_wr   <= pmem_write;
      end
      if (load_rdata) pmem_rdata <= store_rdata;
      if (err_set) protocol_err <= 1'b1;
    end
  end

`ifdef PMEM_STATS_EN
  // Only completed transactions are counted; aborts never reach RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (state == RESP) begin
      if (op_wr) begin
        if (write_count != '1) write_count <= write_count + 32'd1;
      end else begin
        if (read_count != '1) read_count <= read_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: two instances (4/4 latency and
// 1/7 latency with 8-bit aliasing depth); PMEM_STATS_EN also checks counters.
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         p_read  [2];
  logic         p_write [2];
  logic [11:0]  p_addr  [2];
  logic [127:0] p_wdata [2];
  logic         p_resp  [2];
  logic [127:0] p_rdata [2];
  logic         p_err   [2];
`ifdef PMEM_STATS_EN
  logic [31:0]  rc [2];
  logic [31:0]  wc [2];
`endif

  int tests = 0;
  int fails = 0;

  int rd_lat [2] = '{4, 1};
  int wr_lat [2] = '{4, 7};
  int depth  [2] = '{4096, 256};

  logic [127:0] model [int];
  bit           err_exp  [2];
  logic [127:0] last_rd  [2];
  bit           rd_valid [2];
  int           n_reads  [2];
  int           n_writes [2];

  always #5 clk = ~clk;

  pmem_line_responder #(.DEPTH_LOG2(12), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .pmem_read(p_read[0]), .pmem_write(p_write[0]),
    .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]), .pmem_resp(p_resp[0]),
    .pmem_rdata(p_rdata[0]), .protocol_err(p_err[0])
`ifdef PMEM_STATS_EN
    , .read_count(rc[0]), .write_count(wc[0])
`endif
  );

  pmem_line_responder #(.DEPTH_LOG2(8), .READ_LATENCY(1), .WRITE_LATENCY(7)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(p_read[1]), .pmem_write(p_write[1]),
    .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]), .pmem_resp(p_resp[1]),
    .pmem_rdata(p_rdata[1]), .protocol_err(p_err[1])
`ifdef PMEM_STATS_EN
    , .read_count(rc[1]), .write_count(wc[1])
`endif
  );

  typedef struct {
    int           d;
    bit           rd;
    bit           wr;
    logic [11:0]  addr;
    logic [127:0] wd;
    int           exp_lat;
  } vec_t;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int key_of(input int d, input logic [11:0] addr);
    return d * 4096 + (int'(addr) % depth[d]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      err_exp[i]  = 1'b0;
      last_rd[i]  = '0;
      rd_valid[i] = 1'b1;
      n_reads[i]  = 0;
      n_writes[i] = 0;
    end
  endtask

  // One complete transaction; called just after a rising edge with the DUT idle.
  task automatic apply_stimulus(input int d, input bit rd, input bit wr,
                                input logic [11:0] addr, input logic [127:0] wd,
                                input int exp_lat);
    int lat;
    int key;
    bit known;
    logic [127:0] exp_rd;
    key   = key_of(d, addr);
    known = model.exists(key);
    exp_rd = known ? model[key] : '0;
    if (rd && wr) err_exp[d] = 1'b1;
    p_read[d] = rd; p_write[d] = wr; p_addr[d] = addr; p_wdata[d] = wd;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (p_resp[d]) break;
      if (lat == 2) begin
        p_addr[d]  = ~addr;
        p_wdata[d] = ~wd;
      end
    end
    check_output("latency", 128'(lat), 128'(exp_lat));
    if (rd && !wr) begin
      if (known) check_output("rdata", p_rdata[d], exp_rd);
      last_rd[d]  = exp_rd;
      rd_valid[d] = known;
      n_reads[d]++;
    end else begin
      model[key] = wd;
      n_writes[d]++;
    end
    p_read[d] = 1'b0; p_write[d] = 1'b0;
    @(posedge clk); #1;
    check_output("resp_pulse", 128'(p_resp[d]), 128'(0));
    check_output("protocol_err", 128'(p_err[d]), 128'(err_exp[d]));
    if (rd_valid[d]) check_output("rdata_hold", p_rdata[d], last_rd[d]);
  endtask

  // Watches for a bounded window and reports any unexpected response.
  task automatic expect_silence(input int d, input int cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (p_resp[d]) seen = 1'b1;
    end
    check_output(name, 128'(seen), 128'(0));
  endtask

  initial begin
    vec_t vecs [10];
    int c, first, second;
    vecs[0] = '{0, 1'b0, 1'b1, 12'h0A5, 128'h0123456789ABCDEF0123456789ABCDEF, 4};
    vecs[1] = '{0, 1'b1, 1'b0, 12'h0A5, 128'h0, 4};
    vecs[2] = '{0, 1'b0, 1'b1, 12'h020, 128'hDEADBEEF_00000020_CAFEF00D_55AA55AA, 4};
    vecs[3] = '{0, 1'b0, 1'b1, 12'hFA5, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4};
    vecs[4] = '{0, 1'b1, 1'b0, 12'h0A5, 128'h0, 4};
    vecs[5] = '{1, 1'b1, 1'b0, 12'h005, 128'h0, 1};
    vecs[6] = '{1, 1'b0, 1'b1, 12'h105, 128'hA5A5_0105_0000_0000_0000_0000_0000_0105, 7};
    vecs[7] = '{1, 1'b1, 1'b0, 12'h005, 128'h0, 1};
    vecs[8] = '{1, 1'b0, 1'b1, 12'h033, 128'h0F0F_0F0F_3333_3333_0F0F_0F0F_3333_3333, 7};
    vecs[9] = '{1, 1'b1, 1'b0, 12'h033, 128'h0, 1};

    for (int i = 0; i < 2; i++) begin
      p_read[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    model_reset();

    // Reset values while rst is held
    #12;
    for (int i = 0; i < 2; i++) begin
      check_output("reset_resp", 128'(p_resp[i]), 128'(0));
      check_output("reset_rdata", p_rdata[i], 128'(0));
      check_output("reset_err", 128'(p_err[i]), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      apply_stimulus(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_lat);

    // Read held high across RESP is re-accepted in the following idle cycle
    for (int d = 0; d < 2; d++) begin
      p_read[d] = 1'b1; p_addr[d] = (d == 0) ? 12'h0A5 : 12'h033;
      c = 0; first = 0; second = 0;
      while (c < 40 && second == 0) begin
        @(posedge clk); #1;
        c++;
        if (p_resp[d]) begin
          if (first == 0) first = c;
          else second = c;
        end
      end
      p_read[d] = 1'b0;
      check_output("held_first_resp", 128'(first), 128'(rd_lat[d]));
      check_output("held_second_resp", 128'(second), 128'(2 * rd_lat[d] + 1));
      check_output("held_rdata", p_rdata[d], model[key_of(d, p_addr[d])]);
      n_reads[d] += 2;
      @(posedge clk); #1;
    end

    // Randomized traffic against the model
    for (int i = 0; i < 30; i++) begin
      int d;
      bit wr;
      logic [11:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 12'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      apply_stimulus(d, !wr, wr, a, {$urandom, $urandom, $urandom, $urandom},
                     wr ? wr_lat[d] : rd_lat[d]);
    end

    // Read and write together: served as a write, error raised
    apply_stimulus(0, 1'b1, 1'b1, 12'h010, {128{1'b1}}, 4);
    apply_stimulus(0, 1'b1, 1'b0, 12'h010, '0, 4);

    // Write to 0x020 dropped in cycle 2
    p_write[0] = 1'b1; p_addr[0] = 12'h020; p_wdata[0] = 128'hBAD0BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    p_write[0] = 1'b0;
    expect_silence(0, 10, "drop_no_resp");
    check_output("drop_err", 128'(p_err[0]), 128'(1));
    apply_stimulus(0, 1'b1, 1'b0, 12'h020, '0, 4);

    // Write flipped to read during BUSY on the long-latency instance
    p_write[1] = 1'b1; p_addr[1] = 12'h033; p_wdata[1] = 128'hF11F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    p_write[1] = 1'b0; p_read[1] = 1'b1;
    @(posedge clk); #1;
    p_read[1] = 1'b0;
    expect_silence(1, 10, "flip_no_resp");
    check_output("flip_err", 128'(p_err[1]), 128'(1));

`ifdef PMEM_STATS_EN
    check_output("read_count", 128'(rc[0]), 128'(n_reads[0]));
    check_output("write_count", 128'(wc[0]), 128'(n_writes[0]));
    check_output("read_count1", 128'(rc[1]), 128'(n_reads[1]));
    check_output("write_count1", 128'(wc[1]), 128'(n_writes[1]));
`endif

    // Reset during BUSY of a write to 0x0A5
    p_write[0] = 1'b1; p_addr[0] = 12'h0A5; p_wdata[0] = 128'h5EED;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    p_write[0] = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_output("midreset_resp", 128'(p_resp[i]), 128'(0));
      check_output("midreset_rdata", p_rdata[i], 128'(0));
      check_output("midreset_err", 128'(p_err[i]), 128'(0));
    end
`ifdef PMEM_STATS_EN
    check_output("reset_read_count", 128'(rc[0]), 128'(0));
    check_output("reset_write_count", 128'(wc[0]), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    expect_silence(0, 8, "reset_no_resp");
    apply_stimulus(0, 1'b1, 1'b0, 12'h0A5, '0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Physical-memory responder for the cache's line-granular pmem interface: accepts read/write requests on 12-bit line addresses and returns 128-bit lines after a fixed, parameterised latency.
- Used as the behavioural/synthesisable memory behind the L1 cache in the system bench, and as the golden responder when verifying the cache controller.
- Holds its own line storage, a request FSM, a latency counter and protocol-error detection.

Parameters:
- LINE_ADDR_WIDTH, 12, line address width; byte offset is already stripped.
- LINE_WIDTH, 128, data bits per line.
- DEPTH_LOG2, 12, log2 of lines stored; address bits above this alias.
- READ_LATENCY, 4, cycles from accept to pmem_resp for reads; range 1..15.
- WRITE_LATENCY, 4, cycles from accept to pmem_resp for writes; range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  read request, held until pmem_resp.
- pmem_write  in  1  write request, held until pmem_resp.
- pmem_address  in  LINE_ADDR_WIDTH  line address.
- pmem_wdata  in  LINE_WIDTH  write line.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  LINE_WIDTH  read line, valid when pmem_resp is high for a read.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Interface timing: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE; pmem_resp 0; pmem_rdata 0; protocol_err 0; counter 0. Storage contents are not cleared by reset.
- Reset asserted mid-operation: the transaction is abandoned, no pmem_resp is issued and no write is committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if pmem_read or pmem_write is high, accept the request. Capture the address, wdata, op and latency-1 into the counter, then go to BUSY. If the selected latency is 1, go directly to RESP.
- BUSY: decrement the counter each cycle. Go to RESP on the cycle the counter reaches 0.
- RESP: pmem_resp=1 for exactly this cycle, then return to IDLE.
  - Read: pmem_rdata is registered on entry to RESP and holds its value afterwards until the next read.
  - Write: the line is committed at the edge ending RESP.
- Latency: a request accepted in cycle 0 gets pmem_resp in cycle READ_LATENCY (reads) or WRITE_LATENCY (writes).
- Address and wdata are sampled only at accept. Changes during BUSY are ignored.
- A request still high in the IDLE cycle after RESP is a new request. Back-to-back throughput is therefore one transaction per latency+1 cycles.
- Read-after-write to the same line returns the written data.
- Storage index is pmem_address[DEPTH_LOG2-1:0]; higher bits are ignored.
- Error cases (all set protocol_err, which clears only on rst):
  - pmem_read and pmem_write both high at accept: served as a write.
  - Request drops during BUSY: abort to IDLE, no resp, no commit.
  - Op flips during BUSY (read↔write): treated the same as a request drop.

Optional Feature:
- Macro PMEM_STATS_EN.
- Defined: adds outputs read_count[31:0] and write_count[31:0]. Each increments at the edge ending a RESP of that type, saturates at 0xFFFFFFFF and resets to 0. Aborted transactions are not counted.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package pmem_types:
  - pmem_line_t (logic [127:0]), pmem_ladr_t (logic [11:0]).
  - pmem_state_t enum {IDLE, BUSY, RESP}.
  - PMEM_LAT_W = 4.
- Sub-module pmem_line_store: 2**DEPTH_LOG2 x LINE_WIDTH array with synchronous write and combinational read. The FSM lives in pmem_line_responder.

Test Plan:
- Write 0x0123…CDEF to line 0x0A5, then read 0x0A5 → resp exactly 4 cycles after each accept; read returns the written line; protocol_err=0.
- READ_LATENCY=1, WRITE_LATENCY=7: read → resp in cycle 1; write → resp in cycle 7; resp is never high for 2 consecutive cycles.
- Read held high across RESP → second resp at cycle 4+1+4=9 relative to the first accept; rdata unchanged.
- Read and write asserted together on 0x010 with wdata=0xFF..FF → treated as write; protocol_err=1; a later read of 0x010 returns all-ones.
- Drop pmem_write in cycle 2 of a write to 0x020, and separately assert rst during BUSY → no resp; line 0x020 unchanged; state returns to IDLE; outputs at reset values.
- With PMEM_STATS_EN: 3 reads, 2 writes, 1 abort → read_count=3, write_count=2.
